// File: rtl/if_stage_if.sv
// Fetch-stage bundle: instruction-memory port, hazard/redirect controls and IF/ID outputs.
// The fetch stage takes the master side; the memory/pipeline environment takes the slave side.
interface if_stage_if;
    logic [31:0] inst_addr;
    logic [31:0] instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    modport master (
        output inst_addr,
        input  instr,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output ifid_instr,
        output ifid_pc4,
        output ifid_valid,
        output fetch_count
    );

    modport slave (
        input  inst_addr,
        output instr,
        output stall,
        output redirect,
        output redirect_pc,
        input  ifid_instr,
        input  ifid_pc4,
        input  ifid_valid,
        input  fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational instruction memory
// and fills the IF/ID register, honouring stall and redirect-with-flush.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.master  bus
);
    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc4;
    logic [31:0] w_target;

    // pc+4 wraps modulo 2^32; the redirect target is forced word-aligned.
    assign w_pc4    = r_pc + 32'd4;
    assign w_target = bus.redirect_pc & ~32'h0000_0003;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC & ~32'h0000_0003;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_pc4    <= 32'h0000_0000;
            r_ifid_valid  <= 1'b0;
            r_fetch_count <= 32'h0000_0000;
        end else if (bus.redirect) begin
            // The word fetched this cycle is on the wrong path, so IF/ID becomes a bubble.
            r_pc          <= w_target;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_pc4    <= 32'h0000_0000;
            r_ifid_valid  <= 1'b0;
        end else if (!bus.stall) begin
            r_pc          <= w_pc4;
            r_ifid_instr  <= bus.instr;
            r_ifid_pc4    <= w_pc4;
            r_ifid_valid  <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign bus.inst_addr   = r_pc;
    assign bus.ifid_instr  = r_ifid_instr;
    assign bus.ifid_pc4    = r_ifid_pc4;
    assign bus.ifid_valid  = r_ifid_valid;
    assign bus.fetch_count = r_fetch_count;
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a driver applies directed vectors and queues the
// hand-computed post-edge state; a monitor pops and compares after every rising edge.
module tb_if_stage;
    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    logic clk;
    logic reset;
    if_stage_if bus();

    exp_t sb[$];
    vec_t vecs[$];
    int   total;
    int   bad;
    logic stim_done;

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_rd = 32'h2008_0001;
            32'h0000_0004: mem_rd = 32'h2009_0002;
            32'h0000_0008: mem_rd = 32'h200A_0003;
            32'h0000_000C: mem_rd = 32'h200B_0004;
            32'h0000_0040: mem_rd = 32'h8C10_0040;
            32'h0000_0044: mem_rd = 32'h8C11_0044;
            32'hFFFF_FFFC: mem_rd = 32'h1234_5678;
            default:       mem_rd = {16'hDEAD, a[15:0]};
        endcase
    endfunction

    // Memory goes to X whenever the word must not be captured.
    assign bus.instr = (bus.stall || bus.redirect) ? 32'hxxxx_xxxx : mem_rd(bus.inst_addr);

    task automatic add(input logic r, input logic s, input logic d, input logic [31:0] rp,
                       input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                       input logic ev, input logic [31:0] ec);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = d; v.rpc = rp;
        v.e_addr = ea; v.e_instr = ei; v.e_pc4 = ep; v.e_valid = ev; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic chk32(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s txn=%0d actual=%h required=%h", nm, idx, act, req);
        end
    endtask

    // Driver
    initial begin
        stim_done       = 1'b0;
        total           = 0;
        bad             = 0;
        reset           = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        //   rst  stl  red  rpc           addr          ifid_instr    pc4           v     cnt
        add(1'b1,1'b0,1'b0,32'h0,         32'h0,        32'h0,        32'h0,        1'b0, 32'd0);
        add(1'b1,1'b0,1'b0,32'h0,         32'h0,        32'h0,        32'h0,        1'b0, 32'd0);
        add(1'b0,1'b0,1'b0,32'h0,         32'h4,        32'h2008_0001,32'h4,        1'b1, 32'd1);
        add(1'b0,1'b0,1'b0,32'h0,         32'h8,        32'h2009_0002,32'h8,        1'b1, 32'd2);
        add(1'b0,1'b1,1'b0,32'h0,         32'h8,        32'h2009_0002,32'h8,        1'b1, 32'd2);
        add(1'b0,1'b1,1'b0,32'h0,         32'h8,        32'h2009_0002,32'h8,        1'b1, 32'd2);
        add(1'b0,1'b0,1'b0,32'h0,         32'hC,        32'h200A_0003,32'hC,        1'b1, 32'd3);
        add(1'b0,1'b0,1'b1,32'h43,        32'h40,       32'h0,        32'h0,        1'b0, 32'd3);
        add(1'b0,1'b0,1'b0,32'h0,         32'h44,       32'h8C10_0040,32'h44,       1'b1, 32'd4);
        add(1'b0,1'b0,1'b0,32'h0,         32'h48,       32'h8C11_0044,32'h48,       1'b1, 32'd5);
        add(1'b0,1'b1,1'b1,32'h100,       32'h100,      32'h0,        32'h0,        1'b0, 32'd5);
        add(1'b0,1'b0,1'b1,32'h202,       32'h200,      32'h0,        32'h0,        1'b0, 32'd5);
        add(1'b0,1'b1,1'b0,32'h0,         32'h200,      32'h0,        32'h0,        1'b0, 32'd5);
        add(1'b0,1'b0,1'b0,32'h0,         32'h204,      32'hDEAD_0200,32'h204,      1'b1, 32'd6);
        add(1'b1,1'b1,1'b1,32'h300,       32'h0,        32'h0,        32'h0,        1'b0, 32'd0);
        add(1'b0,1'b0,1'b0,32'h0,         32'h4,        32'h2008_0001,32'h4,        1'b1, 32'd1);
        add(1'b0,1'b0,1'b1,32'hFFFF_FFFF, 32'hFFFF_FFFC,32'h0,        32'h0,        1'b0, 32'd1);
        add(1'b0,1'b0,1'b0,32'h0,         32'h0,        32'h1234_5678,32'h0,        1'b1, 32'd2);
        add(1'b0,1'b0,1'b0,32'h0,         32'h4,        32'h2008_0001,32'h4,        1'b1, 32'd3);

        foreach (vecs[i]) begin
            exp_t e;
            @(negedge clk);
            reset           = vecs[i].rst;
            bus.stall       = vecs[i].stall;
            bus.redirect    = vecs[i].redir;
            bus.redirect_pc = vecs[i].rpc;
            e.idx   = i;
            e.addr  = vecs[i].e_addr;
            e.instr = vecs[i].e_instr;
            e.pc4   = vecs[i].e_pc4;
            e.valid = vecs[i].e_valid;
            e.cnt   = vecs[i].e_cnt;
            sb.push_back(e);
        end
        @(negedge clk);
        reset        = 1'b0;
        bus.stall    = 1'b1;
        bus.redirect = 1'b0;
        stim_done    = 1'b1;
    end

    // Monitor
    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && sb.size() == 0) && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk32("inst_addr",   e.idx, bus.inst_addr,   e.addr);
                chk32("ifid_instr",  e.idx, bus.ifid_instr,  e.instr);
                chk32("ifid_pc4",    e.idx, bus.ifid_pc4,    e.pc4);
                chk32("ifid_valid",  e.idx, {31'd0, bus.ifid_valid}, {31'd0, e.valid});
                chk32("fetch_count", e.idx, bus.fetch_count, e.cnt);
                $display("txn %0d: addr=%h ifid_instr=%h pc4=%h valid=%b cnt=%0d",
                         e.idx, bus.inst_addr, bus.ifid_instr, bus.ifid_pc4,
                         bus.ifid_valid, bus.fetch_count);
            end
        end
        if (budget >= 200) begin
            total++;
            bad++;
            $display("FAIL timeout pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
